// File: rtl/cpu_irq_pkg.sv
// Shared types and constants for the fetch-front-end interrupt controller.
package cpu_irq_pkg;

    // Controller sequencing: request raised, vector taken, handler running.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALERT    = 2'd1,
        WAIT_VEC = 2'd2,
        SERVICE  = 2'd3
    } irq_state_t;

    // Address next-PC logic forces on an accepted interrupt.
    localparam logic [31:0] IRQ_VECTOR = 32'd4096;

    // Default number of external request lines.
    localparam int NUM_IRQ_DEFAULT = 8;

    // Width of a cause index; a single line still needs one bit.
    function automatic int cause_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bus between the interrupt controller and the SoC / next-PC logic.
// master: the SoC request lines and the next-PC stage; slave: the controller.
interface irq_controller_if
    import cpu_irq_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT
);
    localparam int CAUSE_W = cause_w(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_in;
    logic               irq_en_we;
    logic [NUM_IRQ-1:0] irq_en_wdata;
    logic               interrupt;
    logic               rti;
    logic               alert;
    logic               interrupt_mask;
    logic [CAUSE_W-1:0] irq_cause;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [NUM_IRQ-1:0] irq_en;

    modport master (
        output irq_in, irq_en_we, irq_en_wdata, interrupt, rti,
        input  alert, interrupt_mask, irq_cause, irq_pending, irq_en
    );

    modport slave (
        input  irq_in, irq_en_we, irq_en_wdata, interrupt, rti,
        output alert, interrupt_mask, irq_cause, irq_pending, irq_en
    );

endinterface

// File: rtl/irq_sync_edge.sv
// One request line: multi-flop synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw,
    output logic sync_lvl,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;

    // Shift the raw line through the synchronizer and keep the previous synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_lvl   = sync_q[SYNC_STAGES-1];
    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches edge events as pending, picks the lowest
// enabled index, and hands it to next-PC logic via a one-cycle alert while
// holding the mask until the handler returns. No nesting.
module irq_controller
    import cpu_irq_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    irq_controller_if.slave  bus
);

    localparam int CAUSE_W = cause_w(NUM_IRQ);

    irq_state_t         state_q;
    irq_state_t         state_n;
    logic [NUM_IRQ-1:0] edge_vec;
    logic [NUM_IRQ-1:0] irq_level_unused;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] en_q;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [CAUSE_W-1:0] winner;
    logic [CAUSE_W-1:0] cause_q;
    logic               req;
    logic               ack;
    logic               alert_q;
    logic               mask_q;

    genvar g;
    generate
        for (g = 0; g < NUM_IRQ; g++) begin : g_line
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk        (clk),
                .rst_n      (rst_n),
                .irq_raw    (bus.irq_in[g]),
                .sync_lvl   (irq_level_unused[g]),
                .edge_pulse (edge_vec[g])
            );
        end
    endgenerate

    assign active = pending_q & en_q;
    assign req    = |active;
    assign ack    = (state_q == WAIT_VEC) && bus.interrupt;

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    // Acknowledge clears only the bit of the cause being taken.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_vec[i] = ack && (cause_q == CAUSE_W'(i));
        end
    end

    // Pending latch: a new edge overrides a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_vec) | edge_vec;
        end
    end

    // Enable register; disabling a line leaves its pending bit alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
        end else if (bus.irq_en_we) begin
            en_q <= bus.irq_en_wdata;
        end
    end

    // State register plus registered alert/mask decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alert_q <= 1'b0;
            mask_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            alert_q <= (state_n == ALERT);
            mask_q  <= (state_n != IDLE);
        end
    end

    // Cause is captured on ALERT entry and held until the next ALERT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= '0;
        end else if ((state_q == IDLE) && req) begin
            cause_q <= winner;
        end
    end

    // Next-state logic; stray rti/interrupt outside their state are ignored.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:     if (req)           state_n = ALERT;
            ALERT:                       state_n = WAIT_VEC;
            WAIT_VEC: if (bus.interrupt) state_n = SERVICE;
            SERVICE:  if (bus.rti)       state_n = IDLE;
            default:                     state_n = IDLE;
        endcase
    end

    assign bus.alert          = alert_q;
    assign bus.interrupt_mask = mask_q;
    assign bus.irq_cause      = cause_q;
    assign bus.irq_pending    = pending_q;
    assign bus.irq_en         = en_q;

endmodule

// File: doc/irq_controller.md
# irq_controller

Collects external interrupt requests, synchronizes and edge-detects them, latches them as pending, and raises a one-cycle `alert` with a held `interrupt_mask` toward the next-PC stage directly downstream. It selects the winning cause by fixed priority and holds the mask through the vector-entry window and the handler. It releases the mask on return-from-interrupt. It sits between the SoC interrupt lines and next-PC selection in the fetch front end.

## Interface
- `NUM_IRQ`, 8, number of external interrupt lines (1–32)
- `SYNC_STAGES`, 2, synchronizer flops per line (≥2)
- `clk` input 1 — single clock; all state on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `irq_in` input NUM_IRQ — raw asynchronous request lines; rising edge = one event
- `irq_en_we` input 1 — write strobe for enable register
- `irq_en_wdata` input NUM_IRQ — new enable mask
- `interrupt` input 1 — one-cycle pulse from next-PC logic when PC is forced to the vector (acknowledge)
- `rti` input 1 — one-cycle pulse when return-from-interrupt retires
- `alert` output 1 — one-cycle request to next-PC logic
- `interrupt_mask` output 1 — high while an interrupt is in flight or in service
- `irq_cause` output clog2(NUM_IRQ) — index of the interrupt being taken/serviced
- `irq_pending` output NUM_IRQ — pending register (readable status)
- `irq_en` output NUM_IRQ — enable register

## Operation
- Per line: SYNC_STAGES-flop synchronizer, then registered previous value; `edge = sync & ~sync_d`.
- `edge[i]` sets `irq_pending[i]`; pending clears only when line i is acknowledged (`interrupt` pulse with `irq_cause==i`). Same-cycle set and clear on the same bit: set wins.
- Enable write applies next cycle; disabling a line does not clear its pending bit.
- `req = |(irq_pending & irq_en)`; winner = lowest set index of `irq_pending & irq_en`.
- FSM states (shared package enum): IDLE, ALERT, WAIT_VEC, SERVICE.
  - IDLE: if `req` → ALERT, latch winner into `irq_cause`.
  - ALERT: `alert=1` for exactly this cycle → WAIT_VEC.
  - WAIT_VEC: wait for `interrupt` → clear pending[cause], go to SERVICE.
  - SERVICE: wait for `rti` → IDLE.
- `interrupt_mask = (state != IDLE)` (registered decode); `alert = (state == ALERT)`.
- `rti` outside SERVICE and `interrupt` outside WAIT_VEC: ignored, no state change.
- `irq_cause` holds from ALERT entry until the next ALERT entry.
- Nesting is not supported; new edges during service only accumulate in pending.

## Timing
- Reset: state IDLE; `alert=0`, `interrupt_mask=0`, `irq_cause=0`, `irq_pending=0`, `irq_en=0`; synchronizers and `sync_d` = 0.
- For `irq_in` high before edge k (SYNC_STAGES=2): sync out at k+1, pending set at k+2, ALERT at k+3 (`alert` high during cycle after k+3 edge).
- Minimum re-alert: `rti` at edge r → IDLE at r; if `req`, ALERT at r+1.
- A line held high produces one event; it must fall and rise again for another.
- Reset mid-operation (any state) returns to reset values on the next evaluation; in-flight cause is lost.

## Structure
- Package `cpu_irq_pkg`: state enum `irq_state_t`, `IRQ_VECTOR = 32'd4096`, default `NUM_IRQ`.
- Sub-module `irq_sync_edge` (parameter SYNC_STAGES; one line in, synced level and edge pulse out), instantiated NUM_IRQ times via generate.
- Top holds pending/enable registers, priority encoder, and FSM.

## Test plan
- Reset, then enable=8'hFF; pulse `irq_in[3]` → pending=8'h08 at k+2, `alert` one cycle at k+3, `irq_cause=3`, mask=1.
- Raise lines 5 and 2 in the same cycle → cause=2 first. After `interrupt`, pending=8'h20. After `rti`, a second alert with cause=5 occurs the next cycle.
- Enable=8'h00, pulse line 0 → pending=8'h01, no alert. Write enable=8'h01 → alert two cycles after the write.
- In SERVICE, pulse line 1 → pending set, no alert, mask stays 1 until `rti`. Next-cycle ALERT follows with cause=1.
- `interrupt` pulse coincident with a new edge on the same line → pending bit remains 1. Stray `rti` and `interrupt` in IDLE → no state change.
- Assert `rst_n=0` in WAIT_VEC → all outputs return to reset values immediately, and no alert follows after release.
